mark_score: RTL and testbench
=============================

# mark_score

Point-scoring block for the two-player ball game. It counts goals for the left and right players from wall-collision events produced by the ball-motion logic. It raises a latched win flag when either side reaches the winning score. Its outputs feed the score display and the game-over logic.

## Interface
Parameters:
- WIN_SCORE, default 9: score at which a player wins; legal range 1–15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Lftcollision  input  1  ball reached the left goal wall; level, synchronous to clk.
- Rgtcollision  input  1  ball reached the right goal wall; level, synchronous to clk.
- Lftscore  output  4  left player's score, unsigned binary.
- Rgtscore  output  4  right player's score, unsigned binary.
- Lftwin  output  1  left player has won; latched until reset.
- Rgtwin  output  1  right player has won; latched until reset.

## Operation
- Each collision input is rising-edge detected. One 0→1 transition scores exactly one point, however long the level is held.
- A rising edge on Lftcollision means the left player missed, so Rgtscore increments.
- A rising edge on Rgtcollision means the right player missed, so Lftscore increments.
- Game-over state: when either win flag is high, both scores freeze and further collision edges are ignored until reset.
- A score reaching WIN_SCORE sets the matching win flag. A score never exceeds WIN_SCORE and never wraps.
- Simultaneous rising edges on both inputs in the same cycle increment both scores.
  - If both scores reach WIN_SCORE in that cycle, both win flags assert; this is a draw.
- Reset values: Lftscore=0, Rgtscore=0, Lftwin=0, Rgtwin=0.
- The edge-detect history registers reset to 1. An input already high when reset is applied or released does not score; it must first return to 0.
- Reset asserted at any time, including mid-game or in game-over, clears state immediately and asynchronously.

## Timing
- The edge-detect history register holds each input's value from the previous clock edge. A scoring pulse is input=1 with history=0.
- Score latency is one edge. When an input is first sampled high at edge N, the score holds its new value after edge N.
- The win flag is registered at that same edge N, computed from the next score value. It never lags the score.
- Minimum event spacing is one low cycle between highs; back-to-back scoring is possible every 2 cycles.
- There are no handshakes; outputs are valid every cycle.

## Structure
- A shared game package holds:
  - SCORE_W = 4
  - the default WIN_SCORE = 9
  - the score type (logic [SCORE_W-1:0]), which is also used by the display decoder.
- Sub-module mark_edge: a single-bit rising-edge detector with reset-to-1 history. It is instantiated once per collision input.
- The top level holds the two saturating score counters and the two win flags, plus the game-over freeze term (Lftwin | Rgtwin).

## Test plan
- Reset held high, then released with both inputs low -> all four outputs 0; no spurious increment in the first cycle.
- 3 isolated pulses on Rgtcollision -> Lftscore=3, Rgtscore=0, no win; each increment appears one edge after the rising edge is sampled.
- Lftcollision toggled every 40 ns, 30 times (15 rising edges) -> Rgtscore counts 1..9, Rgtwin=1 on the 9th edge; the remaining 6 edges leave Rgtscore=9, Lftscore=0, Lftwin=0.
- Lftcollision held high for 20 cycles -> exactly one point.
- Input high when reset is released -> no point until the input falls and rises again.
- Both inputs rise together at 8–8 -> Lftscore=9, Rgtscore=9, Lftwin=Rgtwin=1.
- Reset pulse mid-game at 5–2 -> scores 0–0 and win flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mark_score_pkg.sv
// Shared game package: score width, default winning score, score type and
// the saturating-increment helper used by the score counters.
package mark_score_pkg;

  localparam int unsigned SCORE_W       = 4;
  localparam int unsigned WIN_SCORE_DEF = 9;

  // Score type, also consumed by the score display decoder.
  typedef logic [SCORE_W-1:0] score_t;

  // Advance a score by one when requested, never passing the limit.
  function automatic score_t sat_inc(input score_t s, input logic inc, input score_t lim);
    score_t r;
    r = s;
    if (inc && (s < lim)) begin
      r = s + score_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mark_score_if.sv
// Collision inputs and score/win outputs of the scoring block.
// master: ball-motion side driving collisions and watching the score.
// slave : the scoring block itself.
interface mark_score_if;
  import mark_score_pkg::*;

  logic   Lftcollision;
  logic   Rgtcollision;
  score_t Lftscore;
  score_t Rgtscore;
  logic   Lftwin;
  logic   Rgtwin;

  modport master (
    output Lftcollision,
    output Rgtcollision,
    input  Lftscore,
    input  Rgtscore,
    input  Lftwin,
    input  Rgtwin
  );

  modport slave (
    input  Lftcollision,
    input  Rgtcollision,
    output Lftscore,
    output Rgtscore,
    output Lftwin,
    output Rgtwin
  );

endinterface

// File: rtl/mark_edge.sv
// Single-bit rising-edge detector. History resets to 1 so that an input
// already high around reset does not register an edge until it has been low.
module mark_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic hist;

  // Track the input value seen at the previous clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 1'b1;
    end else begin
      hist <= d;
    end
  end

  assign rise = d & ~hist;

endmodule

// File: rtl/mark_score.sv
// Point scoring for the two-player game. A left-wall collision edge scores
// for the right player and vice versa; scores saturate at WIN_SCORE, which
// latches the matching win flag and freezes both scores until reset.
module mark_score
  import mark_score_pkg::*;
#(
  parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mark_score_if.slave bus
);

  localparam score_t WIN = score_t'(WIN_SCORE);

  logic   lft_rise;
  logic   rgt_rise;
  logic   game_over;
  score_t lft_q;
  score_t rgt_q;
  score_t lft_d;
  score_t rgt_d;
  logic   lftwin_q;
  logic   rgtwin_q;

  mark_edge u_lft_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.Lftcollision),
    .rise  (lft_rise)
  );

  mark_edge u_rgt_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.Rgtcollision),
    .rise  (rgt_rise)
  );

  assign game_over = lftwin_q | rgtwin_q;

  // Next scores: a left-wall hit credits the right player and vice versa.
  always_comb begin
    lft_d = sat_inc(lft_q, rgt_rise & ~game_over, WIN);
    rgt_d = sat_inc(rgt_q, lft_rise & ~game_over, WIN);
  end

  // Win flags come from the next score so they land on the same edge as it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lft_q    <= '0;
      rgt_q    <= '0;
      lftwin_q <= 1'b0;
      rgtwin_q <= 1'b0;
    end else begin
      lft_q    <= lft_d;
      rgt_q    <= rgt_d;
      lftwin_q <= lftwin_q | (lft_d == WIN);
      rgtwin_q <= rgtwin_q | (rgt_d == WIN);
    end
  end

  assign bus.Lftscore = lft_q;
  assign bus.Rgtscore = rgt_q;
  assign bus.Lftwin   = lftwin_q;
  assign bus.Rgtwin   = rgtwin_q;

endmodule

// File: tb/tb_mark_score.sv
module tb_mark_score;
  import mark_score_pkg::*;

  localparam int WIN = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mark_score_if bus ();

  mark_score #(.WIN_SCORE(WIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: game-level view of scores, wins and last-seen inputs.
  int m_ls, m_rs;
  bit m_lw, m_rw;
  bit m_lprev, m_rprev;

  task automatic model_clear();
    m_ls = 0; m_rs = 0; m_lw = 0; m_rw = 0;
    m_lprev = 1; m_rprev = 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Lftscore"}, 8'(bus.Lftscore), 8'(m_ls));
    chk({tag, ".Rgtscore"}, 8'(bus.Rgtscore), 8'(m_rs));
    chk({tag, ".Lftwin"},   8'(bus.Lftwin),   8'(m_lw));
    chk({tag, ".Rgtwin"},   8'(bus.Rgtwin),   8'(m_rw));
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, update
  // the model for that edge, then compare at the following negedge.
  task automatic tick(input bit l, input bit r, input bit rs, input string tag);
    bit lhit, rhit;
    reset = rs;
    bus.Lftcollision = l;
    bus.Rgtcollision = r;
    @(posedge clk);
    if (rs) begin
      model_clear();
    end else begin
      lhit = l && !m_lprev;
      rhit = r && !m_rprev;
      if (!(m_lw || m_rw)) begin
        if (lhit && m_rs < WIN) m_rs++;
        if (rhit && m_ls < WIN) m_ls++;
        if (m_ls == WIN) m_lw = 1;
        if (m_rs == WIN) m_rw = 1;
      end
      m_lprev = l;
      m_rprev = r;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    tick(0, 0, 1, "rst_hold");
    tick(0, 0, 1, "rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    bus.Lftcollision = 1'b0;
    bus.Rgtcollision = 1'b0;
    model_clear();
    @(negedge clk);

    // Reset, then release with inputs low: no spurious point.
    do_reset();
    tick(0, 0, 0, "post_rst0");
    tick(0, 0, 0, "post_rst1");

    // Three isolated right-wall pulses credit the left player.
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, "rgt_pulse");
      tick(0, 0, 0, "rgt_low");
      tick(0, 0, 0, "rgt_gap");
    end
    chk("three_pulses.Lftscore", 8'(bus.Lftscore), 8'd3);
    chk("three_pulses.Rgtscore", 8'(bus.Rgtscore), 8'd0);

    // Left input toggled every 40 ns, 15 rising edges: right wins at 9.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 4; k++) tick(1, 0, 0, "toggle_hi");
      for (int k = 0; k < 4; k++) tick(0, 0, 0, "toggle_lo");
    end
    chk("toggle.Rgtscore", 8'(bus.Rgtscore), 8'(WIN));
    chk("toggle.Rgtwin",   8'(bus.Rgtwin),   8'd1);
    chk("toggle.Lftscore", 8'(bus.Lftscore), 8'd0);
    chk("toggle.Lftwin",   8'(bus.Lftwin),   8'd0);

    // Held high for 20 cycles: exactly one point.
    do_reset();
    tick(0, 0, 0, "hold_pre");
    for (int k = 0; k < 20; k++) tick(1, 0, 0, "hold_hi");
    tick(0, 0, 0, "hold_lo");
    chk("hold.Rgtscore", 8'(bus.Rgtscore), 8'd1);

    // Input high through reset release: no point until it falls and rises.
    tick(1, 1, 1, "hi_rst");
    tick(1, 1, 1, "hi_rst");
    for (int k = 0; k < 3; k++) tick(1, 1, 0, "hi_after_rst");
    chk("hi_rst.Lftscore", 8'(bus.Lftscore), 8'd0);
    tick(0, 0, 0, "hi_fall");
    tick(1, 1, 0, "hi_rise");
    chk("hi_rise.Lftscore", 8'(bus.Lftscore), 8'd1);
    chk("hi_rise.Rgtscore", 8'(bus.Rgtscore), 8'd1);

    // Draw: both reach 8-8, then rise together.
    do_reset();
    tick(0, 0, 0, "draw_pre");
    for (int i = 0; i < 9; i++) begin
      tick(1, 1, 0, "draw_hi");
      tick(0, 0, 0, "draw_lo");
    end
    chk("draw.Lftscore", 8'(bus.Lftscore), 8'(WIN));
    chk("draw.Rgtscore", 8'(bus.Rgtscore), 8'(WIN));
    chk("draw.Lftwin",   8'(bus.Lftwin),   8'd1);
    chk("draw.Rgtwin",   8'(bus.Rgtwin),   8'd1);

    // Mid-game 5-2 then asynchronous reset between clock edges.
    do_reset();
    tick(0, 0, 0, "mid_pre");
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, "mid_r"); tick(0, 0, 0, "mid_lo");
    end
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, "mid_l"); tick(0, 0, 0, "mid_lo");
    end
    chk("mid.Lftscore", 8'(bus.Lftscore), 8'd5);
    chk("mid.Rgtscore", 8'(bus.Rgtscore), 8'd2);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    tick(0, 0, 1, "async_hold");
    reset = 1'b0;

    // Randomised play with occasional resets.
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 99) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
